// File: rtl/branch_ctrl_if.sv
// Execute-stage control-transfer bundle between the pipeline and branch_ctrl.
// The master side drives the execute-stage inputs; the slave side is the controller.
interface branch_ctrl_if;
  logic        valid_in;
  logic        stall;
  logic [4:0]  opcode;
  logic        eq_in;
  logic        gt_in;
  logic [31:0] pc_plus1;
  logic [16:0] imm;
  logic [26:0] target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;
  logic [15:0] taken_count;

  modport master (
    output valid_in, stall, opcode, eq_in, gt_in, pc_plus1, imm, target,
    input  redirect, redirect_pc, flush, busy, taken_count
  );

  modport slave (
    input  valid_in, stall, opcode, eq_in, gt_in, pc_plus1, imm, target,
    output redirect, redirect_pc, flush, busy, taken_count
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch/jump resolution in execute: redirects fetch on a taken transfer and
// squashes the two wrong-path fetch/decode slots behind it.
module branch_ctrl (
  input  logic          clock,
  input  logic          reset,
  branch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FLUSH1 = 2'b01,
    FLUSH2 = 2'b10
  } state_t;

  localparam logic [4:0] OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110;
  localparam logic [4:0] OP_J   = 5'b00001;
  localparam logic [4:0] OP_JAL = 5'b00011;

  state_t      state_q, state_d;
  logic        redirect_q, redirect_d;
  logic        flush_q, flush_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [15:0] taken_count_q, taken_count_d;

  logic        taken;
  logic [31:0] next_pc;

  // blt tests A < B from the A==B / A>B comparator outputs.
  always_comb begin
    taken   = 1'b0;
    next_pc = bus.pc_plus1 + {{15{bus.imm[16]}}, bus.imm};
    unique case (bus.opcode)
      OP_BNE:        taken = ~bus.eq_in;
      OP_BLT:        taken = ~bus.eq_in & ~bus.gt_in;
      OP_J, OP_JAL: begin
        taken   = 1'b1;
        next_pc = {5'b0, bus.target};
      end
      default:       taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    redirect_d    = 1'b0;
    flush_d       = flush_q;
    redirect_pc_d = redirect_pc_q;
    taken_count_d = taken_count_q;
    if (!bus.stall) begin
      unique case (state_q)
        IDLE: begin
          flush_d = 1'b0;
          if (bus.valid_in && taken) begin
            state_d       = FLUSH1;
            redirect_d    = 1'b1;
            flush_d       = 1'b1;
            redirect_pc_d = next_pc;
            taken_count_d = taken_count_q + 16'd1;
          end
        end
        FLUSH1: begin
          state_d = FLUSH2;
          flush_d = 1'b1;
        end
        FLUSH2: begin
          state_d = IDLE;
          flush_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          flush_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_q    <= redirect_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign bus.redirect    = redirect_q;
  assign bus.flush       = flush_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.taken_count = taken_count_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a table of single-instruction vectors plus
// hand-written sequences for wrong-path, stall, reset and counter-wrap cases.
module tb_branch_ctrl;

  logic clock;
  logic reset;
  branch_ctrl_if bus ();

  branch_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #(10 * 400000);
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  op;
    logic        eq;
    logic        gt;
    logic [31:0] pc;
    logic [16:0] imm;
    logic [26:0] tgt;
    logic        taken;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[13];
  int unsigned n_pass;
  int unsigned n_total;
  logic [31:0] exp_pc;
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_in = 1'b0;
    bus.stall    = 1'b0;
    bus.opcode   = 5'b00000;
    bus.eq_in    = 1'b0;
    bus.gt_in    = 1'b0;
    bus.pc_plus1 = '0;
    bus.imm      = '0;
    bus.target   = '0;
  endtask

  task automatic issue(input logic [4:0] op, input logic eq, input logic gt,
                       input logic [31:0] pc, input logic [16:0] imm, input logic [26:0] tgt);
    bus.valid_in = 1'b1;
    bus.stall    = 1'b0;
    bus.opcode   = op;
    bus.eq_in    = eq;
    bus.gt_in    = gt;
    bus.pc_plus1 = pc;
    bus.imm      = imm;
    bus.target   = tgt;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_redirect"}, {31'b0, bus.redirect}, 32'd0);
    chk({tag, "_flush"},    {31'b0, bus.flush},    32'd0);
    chk({tag, "_busy"},     {31'b0, bus.busy},     32'd0);
    chk({tag, "_pc"},       bus.redirect_pc,       32'd0);
    chk({tag, "_count"},    {16'b0, bus.taken_count}, 32'd0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    exp_pc  = '0;
    exp_cnt = '0;

    //               op        eq    gt    pc_plus1      imm       target        taken exp_pc
    vecs[0]  = '{5'b00010, 1'b0, 1'b0, 32'h0000_0010, 17'h1FFFC, 27'h0,        1'b1, 32'h0000_000C};
    vecs[1]  = '{5'b00010, 1'b1, 1'b0, 32'h0000_0040, 17'h00004, 27'h0,        1'b0, 32'h0};
    vecs[2]  = '{5'b00110, 1'b0, 1'b1, 32'h0000_0020, 17'h00005, 27'h0,        1'b0, 32'h0};
    vecs[3]  = '{5'b00110, 1'b0, 1'b0, 32'h0000_0020, 17'h00005, 27'h0,        1'b1, 32'h0000_0025};
    vecs[4]  = '{5'b00110, 1'b1, 1'b0, 32'h0000_0030, 17'h00007, 27'h0,        1'b0, 32'h0};
    vecs[5]  = '{5'b00001, 1'b1, 1'b1, 32'h0000_0050, 17'h00001, 27'h7FFFFFF,  1'b1, 32'h07FF_FFFF};
    vecs[6]  = '{5'b00011, 1'b1, 1'b0, 32'h0000_0060, 17'h00002, 27'h0000123,  1'b1, 32'h0000_0123};
    vecs[7]  = '{5'b00000, 1'b0, 1'b0, 32'h0000_0070, 17'h00003, 27'h0000456,  1'b0, 32'h0};
    vecs[8]  = '{5'b10010, 1'b0, 1'b0, 32'h0000_0080, 17'h00003, 27'h0000456,  1'b0, 32'h0};
    vecs[9]  = '{5'b00010, 1'b0, 1'b1, 32'hFFFF_FFFF, 17'h00002, 27'h0,        1'b1, 32'h0000_0001};
    vecs[10] = '{5'b00010, 1'b0, 1'b0, 32'h0000_0000, 17'h10000, 27'h0,        1'b1, 32'hFFFF_0000};
    vecs[11] = '{5'b00110, 1'b0, 1'b0, 32'h0000_0100, 17'h0FFFF, 27'h0,        1'b1, 32'h0001_00FF};
    vecs[12] = '{5'b00111, 1'b0, 1'b0, 32'h0000_0200, 17'h00009, 27'h0000789,  1'b0, 32'h0};

    // Reset wins over a simultaneous taken jump.
    reset = 1'b1;
    issue(5'b00001, 1'b0, 1'b0, 32'h10, 17'h0, 27'h1234);
    #1;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    idle_inputs();
    tick();

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].eq, vecs[i].gt, vecs[i].pc, vecs[i].imm, vecs[i].tgt);
      tick();
      idle_inputs();
      if (vecs[i].taken) begin
        exp_pc  = vecs[i].exp_pc;
        exp_cnt = exp_cnt + 16'd1;
      end
      chk($sformatf("vec%0d_redirect", i), {31'b0, bus.redirect}, {31'b0, vecs[i].taken});
      chk($sformatf("vec%0d_flush1", i),   {31'b0, bus.flush},    {31'b0, vecs[i].taken});
      chk($sformatf("vec%0d_busy1", i),    {31'b0, bus.busy},     {31'b0, vecs[i].taken});
      chk($sformatf("vec%0d_pc", i),       bus.redirect_pc,       exp_pc);
      chk($sformatf("vec%0d_count", i),    {16'b0, bus.taken_count}, {16'b0, exp_cnt});
      tick();
      chk($sformatf("vec%0d_redirect2", i), {31'b0, bus.redirect}, 32'd0);
      chk($sformatf("vec%0d_flush2", i),    {31'b0, bus.flush},    {31'b0, vecs[i].taken});
      chk($sformatf("vec%0d_busy2", i),     {31'b0, bus.busy},     {31'b0, vecs[i].taken});
      tick();
      chk($sformatf("vec%0d_flush3", i),    {31'b0, bus.flush},    32'd0);
      chk($sformatf("vec%0d_busy3", i),     {31'b0, bus.busy},     32'd0);
    end

    // Wrong-path bne during FLUSH1/FLUSH2 is ignored.
    issue(5'b00001, 1'b0, 1'b0, 32'h0, 17'h0, 27'h7FFFFFF);
    tick();
    exp_pc  = 32'h07FF_FFFF;
    exp_cnt = exp_cnt + 16'd1;
    chk("wp_redirect1", {31'b0, bus.redirect}, 32'd1);
    chk("wp_pc1",       bus.redirect_pc, exp_pc);
    issue(5'b00010, 1'b0, 1'b0, 32'h100, 17'h00004, 27'h0);
    tick();
    chk("wp_redirect2", {31'b0, bus.redirect}, 32'd0);
    chk("wp_flush2",    {31'b0, bus.flush},    32'd1);
    chk("wp_pc2",       bus.redirect_pc, exp_pc);
    tick();
    idle_inputs();
    chk("wp_redirect3", {31'b0, bus.redirect}, 32'd0);
    chk("wp_busy3",     {31'b0, bus.busy},     32'd0);
    chk("wp_count",     {16'b0, bus.taken_count}, {16'b0, exp_cnt});
    tick();
    chk("wp_redirect4", {31'b0, bus.redirect}, 32'd0);
    chk("wp_pc4",       bus.redirect_pc, exp_pc);

    // Stall for 3 cycles starting in FLUSH1.
    issue(5'b00011, 1'b0, 1'b0, 32'h0, 17'h0, 27'h0000055);
    tick();
    exp_pc  = 32'h0000_0055;
    exp_cnt = exp_cnt + 16'd1;
    chk("st_redirect0", {31'b0, bus.redirect}, 32'd1);
    chk("st_flush0",    {31'b0, bus.flush},    32'd1);
    idle_inputs();
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("st%0d_redirect", k), {31'b0, bus.redirect}, 32'd0);
      chk($sformatf("st%0d_flush", k),    {31'b0, bus.flush},    32'd1);
      chk($sformatf("st%0d_busy", k),     {31'b0, bus.busy},     32'd1);
      chk($sformatf("st%0d_pc", k),       bus.redirect_pc,       exp_pc);
      chk($sformatf("st%0d_count", k),    {16'b0, bus.taken_count}, {16'b0, exp_cnt});
    end
    bus.stall = 1'b0;
    tick();
    chk("st_f2_flush",    {31'b0, bus.flush},    32'd1);
    chk("st_f2_busy",     {31'b0, bus.busy},     32'd1);
    chk("st_f2_redirect", {31'b0, bus.redirect}, 32'd0);
    tick();
    chk("st_idle_busy",   {31'b0, bus.busy},     32'd0);
    chk("st_idle_flush",  {31'b0, bus.flush},    32'd0);

    // Stall with a valid taken jump in IDLE: nothing accepted.
    issue(5'b00001, 1'b0, 1'b0, 32'h0, 17'h0, 27'h0000099);
    bus.stall = 1'b1;
    tick();
    tick();
    chk("si_redirect", {31'b0, bus.redirect}, 32'd0);
    chk("si_busy",     {31'b0, bus.busy},     32'd0);
    chk("si_pc",       bus.redirect_pc,       exp_pc);
    chk("si_count",    {16'b0, bus.taken_count}, {16'b0, exp_cnt});
    idle_inputs();
    tick();

    // Reset aborts a flush in FLUSH1.
    issue(5'b00001, 1'b0, 1'b0, 32'h0, 17'h0, 27'h0000042);
    tick();
    idle_inputs();
    chk("rf1_flush_pre", {31'b0, bus.flush}, 32'd1);
    reset = 1'b1;
    tick();
    chk_all_zero("rf1");
    reset = 1'b0;
    exp_pc  = '0;
    exp_cnt = '0;
    tick();

    // Counter wrap: 65535 taken jumps, then one more.
    for (int n = 0; n < 65535; n++) begin
      issue(5'b00001, 1'b0, 1'b0, 32'h0, 17'h0, 27'h0000321);
      tick();
      idle_inputs();
      tick();
      tick();
    end
    chk("wrap_preload", {16'b0, bus.taken_count}, 32'h0000_FFFF);
    chk("wrap_pc",      bus.redirect_pc,          32'h0000_0321);
    issue(5'b00001, 1'b0, 1'b0, 32'h0, 17'h0, 27'h0000777);
    tick();
    idle_inputs();
    chk("wrap_count",    {16'b0, bus.taken_count}, 32'h0000_0000);
    chk("wrap_redirect", {31'b0, bus.redirect},    32'd1);
    chk("wrap_pc2",      bus.redirect_pc,          32'h0000_0777);
    tick();
    chk("rf2_flush_pre", {31'b0, bus.flush}, 32'd1);
    chk("rf2_busy_pre",  {31'b0, bus.busy},  32'd1);
    reset = 1'b1;
    tick();
    chk_all_zero("rf2");
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid_in  input  1  execute stage holds a valid instruction this cycle.
REQ-005 stall  input  1  pipeline stall; freezes this block.
REQ-006 opcode  input  5  execute-stage opcode: 00010 bne, 00110 blt, 00001 j, 00011 jal; all others are non-control.
REQ-007 eq_in  input  1  comparator result: A == B, where A = $rd and B = $rs.
REQ-008 gt_in  input  1  comparator result: A > B.
REQ-009 pc_plus1  input  32  PC of the execute-stage instruction plus 1.
REQ-010 imm  input  17  branch immediate, signed.
REQ-011 target  input  27  jump target field.
REQ-012 redirect  output  1  one-cycle pulse: fetch loads redirect_pc.
REQ-013 redirect_pc  output  32  registered next-PC value.
REQ-014 flush  output  1  squash the fetch/decode latches.
REQ-015 busy  output  1  high while the FSM is not IDLE.
REQ-016 taken_count  output  16  count of taken control transfers.

Function
REQ-017 FSM states SHALL be IDLE, FLUSH1 and FLUSH2, encoded in 2 bits.
REQ-018 Acceptance SHALL occur only when state=IDLE, valid_in=1 and stall=0.
REQ-019 Taken conditions SHALL be:
- bne: eq_in=0.
- blt: eq_in=0 and gt_in=0.
- j and jal: always taken.
- Any other opcode: never taken.
REQ-020 The bne/blt target SHALL be pc_plus1 + sign-extended imm, computed modulo 2^32 with carry-out discarded.
REQ-021 The j/jal target SHALL be {5'b0, target}.
REQ-022 On a taken acceptance, the next edge SHALL:
- Register the target into redirect_pc.
- Set redirect=1 and flush=1.
- Move the FSM to FLUSH1.
- Increment taken_count.
REQ-023 From FLUSH1 with stall=0, the next edge SHALL move to FLUSH2, with redirect=0 and flush=1.
REQ-024 From FLUSH2 with stall=0, the next edge SHALL move to IDLE, with flush=0.
REQ-025 The resulting latency SHALL be: redirect is high exactly 1 cycle after acceptance, and flush is high for cycles 1 and 2 after acceptance.
REQ-026 A not-taken acceptance, or a non-control opcode, SHALL leave the FSM in IDLE, with redirect=0, flush=0 and taken_count unchanged.
REQ-027 valid_in, opcode, eq_in and gt_in SHALL be ignored in FLUSH1 and FLUSH2 (wrong-path instructions).
REQ-028 When stall=1, the next edge SHALL:
- Hold state, flush, redirect_pc and taken_count.
- Force redirect=0.
- Ensure a redirect pulse is never repeated after a stall.
REQ-029 When stall=1 and valid_in=1 occur together in IDLE, stall SHALL win and nothing is accepted.
REQ-030 taken_count SHALL wrap from 0xFFFF to 0x0000.
REQ-031 busy SHALL equal (state != IDLE), decoded combinationally from the state register.
REQ-032 All other outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-033 On a clock edge with reset=1, the block SHALL:
- Set the state to IDLE.
- Set redirect=0, flush=0 and busy=0.
- Set redirect_pc=0x00000000 and taken_count=0x0000.
REQ-034 Reset SHALL take priority over stall and valid_in.
REQ-035 Reset asserted in FLUSH1 or FLUSH2 SHALL abort the flush, with flush=0 on the following cycle.

Verification
REQ-036 bne with pc_plus1=0x00000010, imm=0x1FFFC (-4), eq_in=0 -> redirect pulse one cycle later, redirect_pc=0x0000000C, flush high for 2 cycles, taken_count=1.
REQ-037 blt with eq_in=0, gt_in=1 -> no redirect, flush=0, state stays IDLE; then blt with eq_in=0, gt_in=0, imm=5, pc_plus1=0x20 -> redirect_pc=0x00000025.
REQ-038 j with target=0x7FFFFFF, followed by a bne (eq_in=0) during FLUSH1 -> redirect_pc=0x07FFFFFF, the bne is ignored, exactly one redirect pulse, taken_count=1.
REQ-039 Taken jal, then stall=1 for 3 cycles beginning in FLUSH1 -> flush stays high, redirect=0 while stalled, FLUSH2 is entered after stall drops, busy=0 one cycle after FLUSH2.
REQ-040 Preload taken_count to 0xFFFF via 65535 taken j instructions, then one more taken j -> taken_count=0x0000; reset asserted in FLUSH2 -> IDLE with all outputs 0 on the next cycle.
